// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver.
//   br_cond_e      : condition codes driven on cond_sel by the decoder.
//   BHT_INIT       : reset value of every branch-history counter (weakly not-taken).
//   is_conditional : codes that train the BHT.
//   sat_update     : saturating 2-bit counter step.
package branch_resolver_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_JUMP = 3'd1,
    BR_BEZ  = 3'd2,
    BR_BNE  = 3'd3,
    BR_BEQ  = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_cond_e;

  localparam logic [1:0] BHT_INIT = 2'b01;

  // Only true conditional branches train the predictor; jumps and no-ops do not.
  function automatic logic is_conditional(input br_cond_e c);
    return (c >= BR_BEZ) && (c <= BR_BGEZ);
  endfunction

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && (ctr != 2'b11)) begin
      res = ctr + 2'b01;
    end else if (!taken && (ctr != 2'b00)) begin
      res = ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_resolver_bht_2bit.sv
// Branch history table of 2-bit saturating counters.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (all entries -> BHT_INIT)
//   rd_idx    : asynchronous read index (IF-stage lookup)
//   rd_ctr    : counter value at rd_idx; reflects state before any same-cycle write
//   wr_en     : apply a training update at the next rising edge
//   wr_idx    : entry to train
//   wr_taken  : resolved direction (+1 when taken, -1 when not, saturating)
module branch_resolver_bht_2bit
  import branch_resolver_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr_q [DEPTH];

  // No write-to-read bypass: a same-cycle lookup sees the old counter.
  assign rd_ctr = ctr_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctr_q[i] <= BHT_INIT;
      end
    end else if (wr_en) begin
      ctr_q[wr_idx] <= sat_update(ctr_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// EXE-stage branch resolver with 2-bit BHT prediction and mispredict recovery.
// Resolves the condition for the instruction in EXE, registers the outcome one cycle
// later, trains the BHT on conditional branches and raises a FLUSH_CYCLES-long flush
// to IF/ID on a mispredict. Instructions presented while flush is high are wrong-path
// and are ignored entirely.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   fetch_pc     : IF-stage PC; pred_taken is the MSB of its BHT entry (combinational)
//   valid_in     : EXE holds a control-flow instruction
//   cond_sel     : condition code (br_cond_e)
//   reg1, reg2   : forwarded operands
//   pc_in        : PC of the resolving instruction
//   target_in    : branch/jump target
//   pred_in      : prediction made for this instruction at fetch
//   br_taken     : registered resolved direction
//   mispredict   : registered one-cycle mispredict pulse
//   redirect_pc  : registered correct next PC
//   flush        : registered flush for IF/ID
// Optional (macro BRANCH_STATS_EN): stat_branches, stat_mispredicts saturating counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned BHT_DEPTH    = 16,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fetch_pc,
  output logic             pred_taken,
  input  logic             valid_in,
  input  logic [2:0]       cond_sel,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] target_in,
  input  logic             pred_in,
  output logic             br_taken,
  output logic             mispredict,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

  br_cond_e         cond;
  logic             taken;
  logic             accept;
  logic             wr_bht;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] res_idx;
  logic [1:0]       fetch_ctr;

  logic             br_taken_q,    br_taken_d;
  logic             mispredict_q,  mispredict_d;
  logic [WIDTH-1:0] redirect_q,    redirect_d;
  logic [CNT_W-1:0] flush_cnt_q,   flush_cnt_d;

  // Only the index bits of the PCs feed the BHT; the rest are intentionally dropped.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc, pc_in};

  assign cond      = br_cond_e'(cond_sel);
  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign res_idx   = pc_in[IDX_W+1:2];
  assign flush     = (flush_cnt_q != '0);
  // Wrong-path instructions arrive while flush is high and must have no effect.
  assign accept    = valid_in && !flush;
  assign wr_bht    = accept && is_conditional(cond);

  always_comb begin
    taken = 1'b0;
    case (cond)
      BR_JUMP: taken = 1'b1;
      BR_BEZ:  taken = (reg1 == '0);
      BR_BNE:  taken = (reg1 != reg2);
      BR_BEQ:  taken = (reg1 == reg2);
      BR_BLTZ: taken = reg1[WIDTH-1];
      BR_BGEZ: taken = !reg1[WIDTH-1];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    br_taken_d   = br_taken_q;
    redirect_d   = redirect_q;
    mispredict_d = 1'b0;
    flush_cnt_d  = flush_cnt_q;
    if (accept) begin
      br_taken_d   = taken;
      redirect_d   = taken ? target_in : (pc_in + WIDTH'(4));
      mispredict_d = (taken != pred_in);
    end
    if (mispredict_d) begin
      flush_cnt_d = FLUSH_LOAD;
    end else if (flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_taken_q   <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      flush_cnt_q  <= '0;
    end else begin
      br_taken_q   <= br_taken_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign br_taken    = br_taken_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;

  branch_resolver_bht_2bit #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (fetch_idx),
    .rd_ctr   (fetch_ctr),
    .wr_en    (wr_bht),
    .wr_idx   (res_idx),
    .wr_taken (taken)
  );

  assign pred_taken = fetch_ctr[1];

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (accept && (cond != BR_NONE) && (stat_br_q != '1)) begin
        stat_br_q <= stat_br_q + 32'd1;
      end
      if (mispredict_d && (stat_mp_q != '1)) begin
        stat_mp_q <= stat_mp_q + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule
